// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq shared definitions: state encoding,
// opcode constants, fault codes and opcode classifier.
package ctrl_seq_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_HALT   = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   localparam logic [3:0] OP_LDI = 4'h8;
   localparam logic [3:0] OP_LD  = 4'h9;
   localparam logic [3:0] OP_ST  = 4'hA;
   localparam logic [3:0] OP_JMP = 4'hB;
   localparam logic [3:0] OP_JZ  = 4'hC;
   localparam logic [3:0] OP_ILL = 4'hD;
   localparam logic [3:0] OP_NOP = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] FC_NONE = 2'b00;
   localparam logic [1:0] FC_ILL  = 2'b01;
   localparam logic [1:0] FC_TMO  = 2'b10;

   typedef enum logic [3:0] {
      C_ALU,
      C_LDI,
      C_LD,
      C_ST,
      C_JMP,
      C_JZ,
      C_NOP,
      C_HLT,
      C_ILL
   } op_class_t;

   // hi_set flags opcode bits above the low nibble,
   // which makes any such opcode illegal.
   function automatic op_class_t classify(
      input logic       hi_set,
      input logic [3:0] op
   );
      op_class_t c;
      c = C_ILL;
      if (!hi_set) begin
         unique case (1'b1)
            (op[3] == 1'b0): c = C_ALU;
            (op == OP_LDI):  c = C_LDI;
            (op == OP_LD):   c = C_LD;
            (op == OP_ST):   c = C_ST;
            (op == OP_JMP):  c = C_JMP;
            (op == OP_JZ):   c = C_JZ;
            (op == OP_ILL):  c = C_ILL;
            (op == OP_NOP):  c = C_NOP;
            (op == OP_HLT):  c = C_HLT;
         endcase
      end
      return c;
   endfunction

endpackage

// File: rtl/ctrl_tmo.sv
// ctrl_tmo: bounded memory-wait counter.
// expired flags the wait cycle that would reach 2**TMO_W-1.
module ctrl_tmo #(
   parameter int TMO_W = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic wait_en,
   output logic expired
);

   localparam logic [TMO_W-1:0] LAST =
      TMO_W'((1 << TMO_W) - 2);

   logic [TMO_W-1:0] cnt;

   // count consecutive wait cycles, cleared on completion or idle
   always_ff @(negedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (wait_en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = wait_en && !clr && (cnt == LAST);

endmodule

// File: rtl/ctrl_seq.sv
// ctrl_seq: multi-cycle FETCH/DECODE/EXEC/MEM sequencer
// with memory handshake, timeout and sticky HALT/FAULT.
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int INSTR_W = 8,
   parameter int OPC_W   = 4,
   parameter int TMO_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [INSTR_W-1:0]       instr,
   input  logic                     mem_rdy,
   input  logic                     zero,
   output logic                     fetch,
   output logic                     mem_rd,
   output logic                     mem_wr,
   output logic                     ir_ld,
   output logic                     pc_inc,
   output logic                     pc_ld,
   output logic                     alu_en,
   output logic [2:0]               alu_op,
   output logic                     reg_we,
   output logic                     imm_sel,
   output logic [OPC_W-1:0]         opcode,
   output logic [INSTR_W-OPC_W-1:0] operand,
   output logic                     halted,
   output logic                     fault,
   output logic [1:0]               fault_code
);

   localparam int OPD_W = INSTR_W - OPC_W;

   state_t    state;
   op_class_t cls;
   logic      ld_q;
   logic      jmp_q;
   logic      jz_q;
   logic      ex_we_q;
   logic      waiting;
   logic      tmo_clr;
   logic      tmo_wait;
   logic      tmo_exp;

   assign cls = classify(|(opcode >> 4), opcode[3:0]);

   assign waiting  = (state == S_FETCH) || (state == S_MEM);
   assign tmo_wait = waiting && !mem_rdy;
   assign tmo_clr  = !waiting || mem_rdy;

   ctrl_tmo #(
      .TMO_W(TMO_W)
   ) u_tmo (
      .clk    (clk),
      .rst    (rst),
      .clr    (tmo_clr),
      .wait_en(tmo_wait),
      .expired(tmo_exp)
   );

   // Mealy strobes follow mem_rdy/zero and are killed by rst
   assign ir_ld  = !rst && fetch && mem_rdy;
   assign pc_inc = !rst && fetch && mem_rdy;
   assign reg_we = !rst && (ex_we_q || (ld_q && mem_rdy));
   assign pc_ld  = !rst && (jmp_q || (jz_q && zero));
   assign alu_op = opcode[2:0];

   // state and registered outputs for the state being entered
   always_ff @(negedge clk) begin
      if (rst) begin
         state      <= S_FETCH;
         fetch      <= 1'b1;
         mem_rd     <= 1'b1;
         mem_wr     <= 1'b0;
         alu_en     <= 1'b0;
         imm_sel    <= 1'b0;
         ex_we_q    <= 1'b0;
         jmp_q      <= 1'b0;
         jz_q       <= 1'b0;
         ld_q       <= 1'b0;
         halted     <= 1'b0;
         fault      <= 1'b0;
         fault_code <= FC_NONE;
         opcode     <= '0;
         operand    <= '0;
      end else begin
         fetch   <= 1'b0;
         mem_rd  <= 1'b0;
         mem_wr  <= 1'b0;
         alu_en  <= 1'b0;
         imm_sel <= 1'b0;
         ex_we_q <= 1'b0;
         jmp_q   <= 1'b0;
         jz_q    <= 1'b0;
         ld_q    <= 1'b0;
         unique case (state)
            S_FETCH: begin
               if (mem_rdy) begin
                  state   <= S_DECODE;
                  opcode  <= instr[INSTR_W-1 -: OPC_W];
                  operand <= instr[OPD_W-1:0];
               end else if (tmo_exp) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= FC_TMO;
               end else begin
                  fetch  <= 1'b1;
                  mem_rd <= 1'b1;
               end
            end
            S_DECODE: begin
               unique case (cls)
                  C_ALU: begin
                     state   <= S_EXEC;
                     alu_en  <= 1'b1;
                     ex_we_q <= 1'b1;
                  end
                  C_LDI: begin
                     state   <= S_EXEC;
                     ex_we_q <= 1'b1;
                     imm_sel <= 1'b1;
                  end
                  C_JMP: begin
                     state <= S_EXEC;
                     jmp_q <= 1'b1;
                  end
                  C_JZ: begin
                     state <= S_EXEC;
                     jz_q  <= 1'b1;
                  end
                  C_NOP: begin
                     state <= S_EXEC;
                  end
                  C_LD: begin
                     state  <= S_MEM;
                     mem_rd <= 1'b1;
                     ld_q   <= 1'b1;
                  end
                  C_ST: begin
                     state  <= S_MEM;
                     mem_wr <= 1'b1;
                  end
                  C_HLT: begin
                     state  <= S_HALT;
                     halted <= 1'b1;
                  end
                  default: begin
                     state      <= S_FAULT;
                     fault      <= 1'b1;
                     fault_code <= FC_ILL;
                  end
               endcase
            end
            S_EXEC: begin
               state  <= S_FETCH;
               fetch  <= 1'b1;
               mem_rd <= 1'b1;
            end
            S_MEM: begin
               if (mem_rdy) begin
                  state  <= S_FETCH;
                  fetch  <= 1'b1;
                  mem_rd <= 1'b1;
               end else if (tmo_exp) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= FC_TMO;
               end else begin
                  mem_rd <= mem_rd;
                  mem_wr <= mem_wr;
                  ld_q   <= ld_q;
               end
            end
            S_HALT, S_FAULT: begin
            end
            default: begin
               state      <= S_FAULT;
               fault      <= 1'b1;
               fault_code <= FC_ILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ctrl_seq.sv
// tb_ctrl_seq: directed vectors with a per-cycle scoreboard
// on two ctrl_seq instances (TMO_W = 4 and TMO_W = 2).
module tb_ctrl_seq;

   typedef struct packed {
      logic       fetch;
      logic       mem_rd;
      logic       mem_wr;
      logic       ir_ld;
      logic       pc_inc;
      logic       pc_ld;
      logic       alu_en;
      logic [2:0] alu_op;
      logic       reg_we;
      logic       imm_sel;
      logic [3:0] opcode;
      logic [3:0] operand;
      logic       halted;
      logic       fault;
      logic [1:0] fault_code;
   } o_t;

   typedef struct {
      o_t    e;
      bit    sel;
      string tag;
   } ent_t;

   logic       clk = 1'b1;
   logic       rst = 1'b1;
   logic [7:0] instr = 8'h00;
   logic       mem_rdy = 1'b0;
   logic       zero = 1'b0;

   logic [1:0] fetch_v, mem_rd_v, mem_wr_v, ir_ld_v;
   logic [1:0] pc_inc_v, pc_ld_v, alu_en_v, reg_we_v;
   logic [1:0] imm_sel_v, halted_v, fault_v;
   logic [2:0] alu_op_v [2];
   logic [3:0] opcode_v [2];
   logic [3:0] operand_v [2];
   logic [1:0] fc_v [2];
   o_t         obs [2];

   for (genvar g = 0; g < 2; g++) begin : u
      ctrl_seq #(
         .INSTR_W(8),
         .OPC_W  (4),
         .TMO_W  ((g == 0) ? 4 : 2)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .instr     (instr),
         .mem_rdy   (mem_rdy),
         .zero      (zero),
         .fetch     (fetch_v[g]),
         .mem_rd    (mem_rd_v[g]),
         .mem_wr    (mem_wr_v[g]),
         .ir_ld     (ir_ld_v[g]),
         .pc_inc    (pc_inc_v[g]),
         .pc_ld     (pc_ld_v[g]),
         .alu_en    (alu_en_v[g]),
         .alu_op    (alu_op_v[g]),
         .reg_we    (reg_we_v[g]),
         .imm_sel   (imm_sel_v[g]),
         .opcode    (opcode_v[g]),
         .operand   (operand_v[g]),
         .halted    (halted_v[g]),
         .fault     (fault_v[g]),
         .fault_code(fc_v[g])
      );
      assign obs[g] = {fetch_v[g], mem_rd_v[g], mem_wr_v[g],
                       ir_ld_v[g], pc_inc_v[g], pc_ld_v[g],
                       alu_en_v[g], alu_op_v[g], reg_we_v[g],
                       imm_sel_v[g], opcode_v[g], operand_v[g],
                       halted_v[g], fault_v[g], fc_v[g]};
   end

   always #5 clk = ~clk;

   ent_t       q[$];
   ent_t       mon_e;
   int         vectors = 0;
   int         miscompares = 0;
   bit         sel = 1'b0;
   string      tag = "none";
   logic [3:0] lo = 4'h0;
   logic [3:0] lop = 4'h0;

   // monitor: one expected record per driven cycle, checked mid-cycle
   always @(posedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         vectors++;
         if (obs[mon_e.sel] !== mon_e.e) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t got=%h exp=%h",
                     mon_e.tag, mon_e.sel, $time,
                     obs[mon_e.sel], mon_e.e);
         end
      end
   end

   function automatic o_t base(input logic [3:0] o,
                               input logic [3:0] d);
      o_t e;
      e = '0;
      e.opcode = o;
      e.operand = d;
      e.alu_op = o[2:0];
      return e;
   endfunction

   function automatic o_t fst(input logic [3:0] o,
                              input logic [3:0] d,
                              input logic rdy);
      o_t e;
      e = base(o, d);
      e.fetch = 1'b1;
      e.mem_rd = 1'b1;
      e.ir_ld = rdy;
      e.pc_inc = rdy;
      return e;
   endfunction

   task automatic drive(input logic r, input logic [7:0] ins,
                        input logic rdy, input logic z,
                        input bit chk, input o_t e);
      ent_t t;
      @(negedge clk);
      #1;
      rst = r;
      instr = ins;
      mem_rdy = rdy;
      zero = z;
      if (chk) begin
         t.e = e;
         t.sel = sel;
         t.tag = tag;
         q.push_back(t);
      end
   endtask

   task automatic do_reset();
      drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, base(4'h0, 4'h0));
      drive(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, fst(4'h0, 4'h0, 1'b0));
      lo = 4'h0;
      lop = 4'h0;
   endtask

   task automatic fetch_ok(input logic [7:0] ins);
      drive(1'b0, ins, 1'b1, 1'b0, 1'b1, fst(lo, lop, 1'b1));
      lo = ins[7:4];
      lop = ins[3:0];
   endtask

   task automatic simple(input logic [7:0] ins, input logic z,
                         input logic alu, input logic we,
                         input logic imm, input logic pcl);
      o_t e;
      fetch_ok(ins);
      drive(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, base(lo, lop));
      e = base(lo, lop);
      e.alu_en = alu;
      e.reg_we = we;
      e.imm_sel = imm;
      e.pc_ld = pcl;
      drive(1'b0, 8'hFF, 1'b1, z, 1'b1, e);
   endtask

   initial begin
      o_t e;
      int n;

      sel = 1'b0;
      tag = "reset";
      do_reset();

      tag = "alu35";
      simple(8'h35, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tag = "alu07";
      simple(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tag = "jz_z1";
      simple(8'hC7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tag = "jz_z0";
      simple(8'hC7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tag = "jmp";
      simple(8'hB3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tag = "ldi";
      simple(8'h8A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tag = "nop";
      simple(8'hE0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      tag = "ld_wait";
      fetch_ok(8'h92);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, base(4'h9, 4'h2));
      e = base(4'h9, 4'h2);
      e.mem_rd = 1'b1;
      repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, e);
      e.reg_we = 1'b1;
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, e);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, fst(4'h9, 4'h2, 1'b0));

      tag = "st_nowait";
      fetch_ok(8'hA4);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, base(4'hA, 4'h4));
      e = base(4'hA, 4'h4);
      e.mem_wr = 1'b1;
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, e);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, fst(4'hA, 4'h4, 1'b0));

      tag = "illegal";
      do_reset();
      fetch_ok(8'hD0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, base(4'hD, 4'h0));
      e = base(4'hD, 4'h0);
      e.fault = 1'b1;
      e.fault_code = 2'b01;
      repeat (2) drive(1'b0, 8'h35, 1'b1, 1'b1, 1'b1, e);

      tag = "halt";
      do_reset();
      fetch_ok(8'hF0);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, base(4'hF, 4'h0));
      e = base(4'hF, 4'h0);
      e.halted = 1'b1;
      repeat (3) drive(1'b0, 8'h35, 1'b1, 1'b1, 1'b1, e);
      tag = "halt_rst";
      do_reset();

      tag = "st_rst";
      fetch_ok(8'hA4);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, base(4'hA, 4'h4));
      e = base(4'hA, 4'h4);
      e.mem_wr = 1'b1;
      repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, e);
      drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, e);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, fst(4'h0, 4'h0, 1'b0));

      sel = 1'b1;
      tag = "tmo_fetch";
      do_reset();
      repeat (3)
         drive(1'b0, 8'h35, 1'b0, 1'b0, 1'b1, fst(4'h0, 4'h0, 1'b0));
      e = base(4'h0, 4'h0);
      e.fault = 1'b1;
      e.fault_code = 2'b10;
      repeat (2) drive(1'b0, 8'h35, 1'b1, 1'b0, 1'b1, e);

      tag = "tmo_edge";
      do_reset();
      repeat (2)
         drive(1'b0, 8'h35, 1'b0, 1'b0, 1'b1, fst(4'h0, 4'h0, 1'b0));
      fetch_ok(8'h35);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, base(4'h3, 4'h5));
      e = base(4'h3, 4'h5);
      e.alu_en = 1'b1;
      e.reg_we = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, e);

      tag = "tmo_mem";
      fetch_ok(8'h92);
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, base(4'h9, 4'h2));
      e = base(4'h9, 4'h2);
      e.mem_rd = 1'b1;
      repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, e);
      e = base(4'h9, 4'h2);
      e.fault = 1'b1;
      e.fault_code = 2'b10;
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, e);

      n = 0;
      while (q.size() > 0 && n < 10) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
